// File: rtl/pc_commit_pkg.sv
// Shared types and constants for the PC commit unit.
// The misaligned-jump trap is built only when PC_MISALIGN_CHECK_EN is defined.
package pc_commit_pkg;

   typedef enum logic {
      IDLE     = 1'b0,
      WAIT_LSU = 1'b1
   } state_e;

   localparam logic [3:0] EXC_CAUSE_INSN_MISALIGNED = 4'd0;

endpackage

// File: rtl/retire_cnt.sv
// Retired-instruction counter.
// It wraps naturally from all-ones to zero.
module retire_cnt #(
   parameter int CNT_W = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (inc) count_d = count_q + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) count_q <= '0;
      else      count_q <= count_d;
   end

   assign count = count_q;

endmodule

// File: rtl/pc_commit_unit.sv
// Architectural PC commit unit: sequential/jump/trap PC update, waiting on the LSU when needed.
// Build option: PC_MISALIGN_CHECK_EN turns a misaligned taken jump into a trap.
//
// state    | meaning
// IDLE     | accepting an instruction; non-memory commits update the PC immediately
// WAIT_LSU | memory access outstanding; PC updates from latched fields on lsu_done
module pc_commit_unit
   import pc_commit_pkg::*;
#(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] PC_START = 32'h8000_0000,
   parameter int              CNT_W    = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             jump_taken,
   input  logic [XLEN-1:0]  pc_jump,
   input  logic             trap,
   input  logic [XLEN-1:0]  mtvec,
   input  logic             lsu_req,
   input  logic             lsu_done,
   output logic [XLEN-1:0]  pc_reg,
   output logic             pc_update_en,
   output logic             exc_valid,
   output logic [XLEN-1:0]  exc_tval,
   output logic [CNT_W-1:0] instret
);

   state_e          state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic            jmp_q, jmp_d;
   logic [XLEN-1:0] tgt_q, tgt_d;
   logic            trap_q, trap_d;

   logic            upd;
   logic            sel_jmp;
   logic [XLEN-1:0] sel_tgt;
   logic            sel_trap;
   logic            misalign;
   logic            take_exc;

   always_comb begin
      state_d  = state_q;
      jmp_d    = jmp_q;
      tgt_d    = tgt_q;
      trap_d   = trap_q;
      upd      = 1'b0;
      sel_jmp  = jump_taken;
      sel_tgt  = pc_jump;
      sel_trap = trap;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               if (lsu_req) begin
                  jmp_d   = jump_taken;
                  tgt_d   = pc_jump;
                  trap_d  = trap;
                  state_d = WAIT_LSU;
               end else begin
                  upd = 1'b1;
               end
            end
         end
         WAIT_LSU: begin
            sel_jmp  = jmp_q;
            sel_tgt  = tgt_q;
            sel_trap = trap_q;
            if (lsu_done) begin
               upd     = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

`ifdef PC_MISALIGN_CHECK_EN
   assign misalign = sel_jmp & (sel_tgt[1:0] != 2'b00);
`else
   assign misalign = 1'b0;
`endif

   assign take_exc = sel_trap | misalign;

   // mtvec is sampled live at the update, not latched at handshake.
   always_comb begin
      pc_d = pc_q;
      if (upd) begin
         if (take_exc)     pc_d = mtvec;
         else if (sel_jmp) pc_d = sel_tgt;
         else              pc_d = pc_q + XLEN'(4);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         pc_q    <= PC_START;
         jmp_q   <= 1'b0;
         tgt_q   <= '0;
         trap_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         jmp_q   <= jmp_d;
         tgt_q   <= tgt_d;
         trap_q  <= trap_d;
      end
   end

   // Pulses are gated by rst so they read zero while reset is held.
   assign in_ready     = (state_q == IDLE);
   assign pc_update_en = upd & rst;
   assign exc_valid    = pc_update_en & take_exc;
   assign exc_tval     = exc_valid ? (sel_trap ? pc_q : sel_tgt) : '0;
   assign pc_reg       = pc_q;

   retire_cnt #(
      .CNT_W (CNT_W)
   ) u_retire_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (pc_update_en & ~exc_valid),
      .count (instret)
   );

endmodule

// File: tb/tb_pc_commit_unit.sv
// Randomized self-checking bench for pc_commit_unit against a queue-based commit model.
// Honors PC_MISALIGN_CHECK_EN the same way the design does.
module tb_pc_commit_unit;

   localparam logic [31:0] PC_START = 32'h8000_0000;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic        jump_taken;
   logic [31:0] pc_jump;
   logic        trap;
   logic [31:0] mtvec;
   logic        lsu_req;
   logic        lsu_done;
   logic [31:0] pc_reg;
   logic        pc_update_en;
   logic        exc_valid;
   logic [31:0] exc_tval;
   logic [63:0] instret;

   pc_commit_unit dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .jump_taken   (jump_taken),
      .pc_jump      (pc_jump),
      .trap         (trap),
      .mtvec        (mtvec),
      .lsu_req      (lsu_req),
      .lsu_done     (lsu_done),
      .pc_reg       (pc_reg),
      .pc_update_en (pc_update_en),
      .exc_valid    (exc_valid),
      .exc_tval     (exc_tval),
      .instret      (instret)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        jt;
      logic [31:0] tgt;
      logic        tr;
   } pend_t;

   pend_t       pq[$];
   logic [31:0] m_pc;
   logic [63:0] m_cnt;
   logic [31:0] n_pc;
   logic [63:0] n_cnt;
   logic        e_upd, e_exc;
   logic [31:0] e_tval;

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Architectural effect of one committed instruction.
   task automatic model_commit(input logic jt, input logic [31:0] tgt, input logic tr,
                               input logic [31:0] mtv);
      logic mis;
`ifdef PC_MISALIGN_CHECK_EN
      mis = jt && (tgt % 4 != 0);
`else
      mis = 1'b0;
`endif
      e_upd = 1'b1;
      if (tr) begin
         n_pc = mtv; e_exc = 1'b1; e_tval = m_pc;
      end else if (mis) begin
         n_pc = mtv; e_exc = 1'b1; e_tval = tgt;
      end else begin
         n_pc  = jt ? tgt : 32'((64'(m_pc) + 64'd4) % 64'h1_0000_0000);
         n_cnt = m_cnt + 64'd1;
      end
   endtask

   task automatic step(input logic v, input logic lreq, input logic jt, input logic [31:0] tgt,
                       input logic tr, input logic [31:0] mtv, input logic ld);
      logic  exp_rdy;
      pend_t p;
      @(negedge clk);
      in_valid = v; lsu_req = lreq; jump_taken = jt; pc_jump = tgt;
      trap = tr; mtvec = mtv; lsu_done = ld;
      #1;
      exp_rdy = (pq.size() == 0);
      e_upd = 1'b0; e_exc = 1'b0; e_tval = '0; n_pc = m_pc; n_cnt = m_cnt;
      if (exp_rdy) begin
         if (v) begin
            if (lreq) begin
               p.jt = jt; p.tgt = tgt; p.tr = tr;
               pq.push_back(p);
            end else begin
               model_commit(jt, tgt, tr, mtv);
            end
         end
      end else if (ld) begin
         p = pq.pop_front();
         model_commit(p.jt, p.tgt, p.tr, mtv);
      end
      chk("in_ready", 64'(in_ready), 64'(exp_rdy));
      chk("pc_update_en", 64'(pc_update_en), 64'(e_upd));
      chk("exc_valid", 64'(exc_valid), 64'(e_exc));
      chk("exc_tval", 64'(exc_tval), 64'(e_tval));
      @(posedge clk);
      #1;
      m_pc = n_pc; m_cnt = n_cnt;
      chk("pc_reg", 64'(pc_reg), 64'(m_pc));
      chk("instret", instret, m_cnt);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      in_valid = 1'b1; lsu_req = 1'b0; lsu_done = 1'b1; trap = 1'b1;
      #1;
      chk("rst_pc", 64'(pc_reg), 64'(PC_START));
      chk("rst_instret", instret, 64'd0);
      chk("rst_upd", 64'(pc_update_en), 64'd0);
      chk("rst_exc", 64'(exc_valid), 64'd0);
      chk("rst_tval", 64'(exc_tval), 64'd0);
      chk("rst_ready", 64'(in_ready), 64'd1);
      @(negedge clk);
      in_valid = 1'b0; lsu_done = 1'b0; trap = 1'b0;
      rst = 1'b1;
      pq.delete();
      m_pc = PC_START; m_cnt = '0;
   endtask

   localparam logic [31:0] MTV = 32'h8000_0200;

   initial begin
      rst = 1'b0; in_valid = 1'b0; lsu_req = 1'b0; jump_taken = 1'b0; pc_jump = '0;
      trap = 1'b0; mtvec = MTV; lsu_done = 1'b0;
      m_pc = PC_START; m_cnt = '0;
      do_reset();

      // three sequential commits
      for (int i = 0; i < 3; i++) step(1, 0, 0, 32'h0, 0, MTV, 0);
      chk("seq_pc", 64'(pc_reg), 64'h8000_000C);
      chk("seq_cnt", instret, 64'd3);

      // memory commit with jump, lsu_done five cycles later
      step(1, 1, 1, 32'h8000_0100, 0, MTV, 0);
      for (int i = 0; i < 4; i++) step(1, 0, 0, 32'h0, 0, MTV, 0);
      chk("lsu_hold_pc", 64'(pc_reg), 64'h8000_000C);
      step(1, 0, 0, 32'h0, 0, MTV, 1);
      chk("lsu_jump_pc", 64'(pc_reg), 64'h8000_0100);
      chk("lsu_cnt", instret, 64'd4);

      // trap beats jump
      step(1, 0, 1, 32'h8000_0010, 0, MTV, 0);
      step(1, 0, 1, 32'h8000_0400, 1, MTV, 0);
      chk("trap_pc", 64'(pc_reg), 64'h8000_0200);
      chk("trap_cnt", instret, 64'd5);

      // misaligned jump target
      step(1, 0, 1, 32'h8000_0102, 0, 32'h8000_0300, 0);
`ifdef PC_MISALIGN_CHECK_EN
      chk("misalign_pc", 64'(pc_reg), 64'h8000_0300);
      chk("misalign_cnt", instret, 64'd5);
`else
      chk("misalign_pc", 64'(pc_reg), 64'h8000_0102);
      chk("misalign_cnt", instret, 64'd6);
`endif

      // reset while waiting on the LSU, then a stray lsu_done
      step(1, 1, 1, 32'h8000_0800, 0, MTV, 0);
      chk("wait_ready", 64'(in_ready), 64'd0);
      do_reset();
      step(0, 0, 0, 32'h0, 0, MTV, 1);
      chk("abandon_pc", 64'(pc_reg), 64'(PC_START));
      chk("abandon_cnt", instret, 64'd0);

      // PC wrap
      step(1, 0, 1, 32'hFFFF_FFFC, 0, MTV, 0);
      step(1, 0, 0, 32'h0, 0, MTV, 0);
      chk("wrap_pc", 64'(pc_reg), 64'h0);

      // randomized traffic with occasional resets
      for (int i = 0; i < 1500; i++) begin
         logic [31:0] t;
         t = $urandom();
         if ($urandom_range(3) != 0) t = t & 32'hFFFF_FFFC;
         step($urandom_range(3) != 0, $urandom_range(2) == 0, $urandom_range(3) == 0, t,
              $urandom_range(7) == 0, $urandom() & 32'hFFFF_FFFC, $urandom_range(2) == 0);
         if (i % 400 == 399) do_reset();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
